// File: rtl/seq_step_ctrl.sv
// seq_step_ctrl: drives the one-bit advance input of a three-state Moore
// controller. It times dwell intervals in S1/S2, issues registered step pulses
// and supports single-shot or looping operation with a graceful stop.
module seq_step_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [CNT_W-1:0] dwell1,
    input  logic [CNT_W-1:0] dwell2,
    output logic             step,
    output logic [1:0]       phase,
    output logic             busy,
    output logic             done,
    output logic [7:0]       cycles
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StWait1 = 2'b01,
        StWait2 = 2'b10,
        StPass  = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stop_pend_q, stop_pend_d;
    logic             step_q, step_d;
    logic             done_q, done_d;
    logic [7:0]       cycles_q, cycles_d;

    // Next-state, dwell counting and pulse generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        // A stop seen while busy is remembered until the sequence finishes.
        stop_pend_d = stop_pend_q | (stop & (state_q != StIdle));
        step_d      = 1'b0;
        done_d      = 1'b0;
        cycles_d    = cycles_q;

        case (state_q)
            StIdle: begin
                // stop wins over a simultaneous start
                if (start && !stop) begin
                    state_d     = StWait1;
                    cnt_d       = dwell1;
                    cycles_d    = 8'd0;
                    stop_pend_d = 1'b0;
                end
            end
            StWait1: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntOne;
                end else begin
                    state_d = StWait2;
                    cnt_d   = dwell2;
                    step_d  = 1'b1;
                end
            end
            StWait2: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntOne;
                end else begin
                    state_d  = StPass;
                    step_d   = 1'b1;
                    cycles_d = (cycles_q == 8'hFF) ? cycles_q : cycles_q + 8'd1;
                end
            end
            StPass: begin
                if (loop_en && !stop_pend_q && !stop) begin
                    state_d = StWait1;
                    cnt_d   = dwell1;
                end else begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
            cycles_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            step_q      <= step_d;
            done_q      <= done_d;
            cycles_q    <= cycles_d;
        end
    end

    // phase mirrors the controlled FSM's output one cycle ahead; busy is any non-idle state.
    always_comb begin
        case (state_q)
            StWait1: phase = 2'b10;
            StWait2: phase = 2'b11;
            default: phase = 2'b01;
        endcase
        busy = (state_q != StIdle);
    end

    assign step   = step_q;
    assign done   = done_q;
    assign cycles = cycles_q;

endmodule
